// File: rtl/ro_puf_sequencer_pkg.sv
// Shared types and default constants for the RO PUF sequencer.
// Holds the FSM state encoding and a width helper.
package ro_puf_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    HOLD,
    COMPARE,
    DONE
  } state_e;

  localparam int NUM_RO_D = 16;
  localparam int SEL_W_D  = 4;
  localparam int CNT_W_D  = 12;
  localparam int WINDOW_D = 4000;
  localparam int CLR_D    = 4;
  localparam int HOLD_D   = 4;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ro_puf_sequencer_if.sv
// Response handshake bundle between the PUF sequencer
// and its consumer.
interface ro_puf_sequencer_if #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = 4
);
  logic [NUM_RO-1:0] response;
  logic              resp_valid;
  logic              resp_ready;
  logic [SEL_W:0]    tie_cnt;
  logic              sat_flag;

  modport master (
    output response,
    output resp_valid,
    output tie_cnt,
    output sat_flag,
    input  resp_ready
  );

  modport slave (
    input  response,
    input  resp_valid,
    input  tie_cnt,
    input  sat_flag,
    output resp_ready
  );
endinterface

// File: rtl/ro_puf_sequencer_timer.sv
// Loadable down-counter shared by all timed phases.
// zero is high once the loaded count has run out.
module puf_phase_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/ro_puf_sequencer.sv
// Challenge sequencer / response collector for the RO PUF.
// Steps RO pairs, compares edge counts, builds one response word.
module ro_puf_sequencer
  import ro_puf_sequencer_pkg::*;
#(
  parameter int NUM_RO      = NUM_RO_D,
  parameter int SEL_W       = SEL_W_D,
  parameter int CNT_W       = CNT_W_D,
  parameter int WINDOW      = WINDOW_D,
  parameter int CLR_CYCLES  = CLR_D,
  parameter int HOLD_CYCLES = HOLD_D
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             ro_enable,
  output logic             ro_reset,
  output logic             busy,
  ro_puf_sequencer_if.master rsp
);
  localparam int TW =
    $clog2(max3(WINDOW, CLR_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [SEL_W-1:0] K_LAST = SEL_W'(NUM_RO - 1);

  state_e           state, state_d;
  logic [SEL_W-1:0] k, k_d;
  logic             load, zero;
  logic [TW-1:0]    load_val;

  logic [SEL_W-1:0]  sel_a_d, sel_b_d;
  logic              ro_en_d, ro_rst_d, busy_d, valid_d;
  logic [NUM_RO-1:0] resp_d;
  logic [SEL_W:0]    tie_d;
  logic              sat_d;

  puf_phase_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .tick     (1'b1),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      k              <= '0;
      sel_a          <= '0;
      sel_b          <= SEL_W'(1);
      ro_enable      <= 1'b0;
      ro_reset       <= 1'b1;
      busy           <= 1'b0;
      rsp.resp_valid <= 1'b0;
      rsp.response   <= '0;
      rsp.tie_cnt    <= '0;
      rsp.sat_flag   <= 1'b0;
    end else begin
      state          <= state_d;
      k              <= k_d;
      sel_a          <= sel_a_d;
      sel_b          <= sel_b_d;
      ro_enable      <= ro_en_d;
      ro_reset       <= ro_rst_d;
      busy           <= busy_d;
      rsp.resp_valid <= valid_d;
      rsp.response   <= resp_d;
      rsp.tie_cnt    <= tie_d;
      rsp.sat_flag   <= sat_d;
    end
  end

  always_comb begin
    state_d = state;
    k_d     = k;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_d     = '0;
        end
      end
      CLEAR:   if (zero) state_d = MEASURE;
      MEASURE: if (zero) state_d = HOLD;
      HOLD:    if (zero) state_d = COMPARE;
      COMPARE: begin
        if (k == K_LAST) begin
          state_d = DONE;
        end else begin
          state_d = CLEAR;
          k_d     = k + 1'b1;
        end
      end
      DONE:    if (rsp.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer is armed on the edge that enters a timed phase.
  always_comb begin
    load     = (state_d != state);
    load_val = '0;
    unique case (1'b1)
      state_d == CLEAR:   load_val = TW'(CLR_CYCLES - 1);
      state_d == MEASURE: load_val = TW'(WINDOW - 1);
      state_d == HOLD:    load_val = TW'(HOLD_CYCLES - 1);
      default:            load_val = '0;
    endcase
  end

  always_comb begin
    ro_rst_d = (state_d == IDLE) || (state_d == CLEAR)
            || (state_d == DONE);
    ro_en_d  = (state_d == MEASURE);
    busy_d   = (state_d != IDLE);
    valid_d  = (state_d == DONE);
    sel_a_d  = sel_a;
    sel_b_d  = sel_b;
    resp_d   = rsp.response;
    tie_d    = rsp.tie_cnt;
    sat_d    = rsp.sat_flag;
    if (state_d == CLEAR) begin
      sel_a_d = k_d;
      sel_b_d = (k_d == K_LAST) ? '0 : k_d + 1'b1;
    end
    if (state == IDLE && start) begin
      resp_d = '0;
      tie_d  = '0;
      sat_d  = 1'b0;
    end
    if (state == COMPARE) begin
      resp_d[k] = (count_a > count_b);
      if (count_a == count_b) tie_d = tie_d + 1'b1;
      if ((&count_a) || (&count_b)) sat_d = 1'b1;
    end
  end
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Self-checking bench for ro_puf_sequencer with a
// frequency-table RO model and a reference response model.
module tb_ro_puf_sequencer;
  localparam int N   = 16;
  localparam int WIN = 16;
  localparam int CLR = 4;
  localparam int HLD = 4;
  localparam int PAIR_LAT = CLR + WIN + HLD + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] count_a, count_b;
  logic [3:0]  sel_a, sel_b;
  logic        ro_enable, ro_reset, busy;
  logic [11:0] f [N];

  int n_asrt = 0;
  int n_fail = 0;

  ro_puf_sequencer_if #(.NUM_RO(N), .SEL_W(4)) u_if ();

  ro_puf_sequencer #(
    .NUM_RO(N), .SEL_W(4), .CNT_W(12),
    .WINDOW(WIN), .CLR_CYCLES(CLR), .HOLD_CYCLES(HLD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .count_a   (count_a),
    .count_b   (count_b),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .ro_enable (ro_enable),
    .ro_reset  (ro_reset),
    .busy      (busy),
    .rsp       (u_if)
  );

  always #5 clock = ~clock;

  // RO model: counters read zero while cleared, else the table value.
  assign count_a = ro_reset ? 12'd0 : f[sel_a];
  assign count_b = ro_reset ? 12'd0 : f[sel_b];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(output logic [15:0] r,
                                output int t,
                                output bit s);
    r = '0;
    t = 0;
    s = 1'b0;
    for (int i = 0; i < N; i++) begin
      int a, b;
      a = int'(f[i]);
      b = int'(f[(i + 1) % N]);
      r[i] = (a > b);
      if (a == b) t++;
      if (a == 4095 || b == 4095) s = 1'b1;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic handshake(input logic [15:0] er);
    u_if.resp_ready = 1'b1;
    cyc(1);
    u_if.resp_ready = 1'b0;
    chk("hs_valid", u_if.resp_valid, 0);
    chk("hs_busy", busy, 0);
    chk("hs_keep", u_if.response, er);
  endtask

  task automatic run_resp(input string tag,
                          output logic [15:0] er);
    int et;
    bit es;
    int n;
    model(er, et, es);
    pulse_start();
    n = 0;
    while (!u_if.resp_valid && n < 2000) begin
      cyc(1);
      n++;
    end
    chk({tag, "_lat"}, n, N * PAIR_LAT);
    chk({tag, "_resp"}, u_if.response, er);
    chk({tag, "_tie"}, u_if.tie_cnt, et);
    chk({tag, "_sat"}, u_if.sat_flag, es);
  endtask

  // Per-pair phase timing and select stability.
  int   en_run = 0;
  int   clr_run = 0;
  logic prev_en = 1'b0;
  logic [3:0] win_sel;
  always @(negedge clock) begin
    if (reset) begin
      en_run  = 0;
      clr_run = 0;
      prev_en = 1'b0;
    end else begin
      if (ro_enable) begin
        if (!prev_en) begin
          chk("clr_len", clr_run, CLR);
          chk("sel_b", sel_b, (int'(sel_a) + 1) % N);
          win_sel = sel_a;
        end else begin
          chk("sel_hold", sel_a, win_sel);
        end
        en_run++;
      end else begin
        if (prev_en) begin
          chk("win_len", en_run, WIN);
          en_run  = 0;
          clr_run = 0;
        end
        if (busy && ro_reset && !u_if.resp_valid) clr_run++;
      end
      prev_en = ro_enable;
    end
  end

  initial begin
    logic [15:0] er;
    u_if.resp_ready = 1'b0;
    for (int i = 0; i < N; i++) f[i] = 12'(100 + i);
    cyc(2);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 1);
    chk("rst_en", ro_enable, 0);
    chk("rst_clr", ro_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp", u_if.response, 0);
    chk("rst_valid", u_if.resp_valid, 0);
    chk("rst_tie", u_if.tie_cnt, 0);
    chk("rst_sat", u_if.sat_flag, 0);
    reset = 1'b0;
    cyc(1);

    run_resp("t1", er);
    chk("t1_const", u_if.response, 16'h8000);
    handshake(er);

    for (int i = 0; i < N; i++) f[i] = 12'd500;
    run_resp("t2", er);
    chk("t2_tie16", u_if.tie_cnt, 16);
    handshake(er);

    for (int i = 0; i < N; i++) f[i] = 12'(100 + i);
    f[3] = 12'hFFF;
    run_resp("t3", er);
    chk("t3_bit2", u_if.response[2], 0);
    chk("t3_bit3", u_if.response[3], 1);
    handshake(er);
    f[3] = 12'd103;
    run_resp("t3b", er);
    handshake(er);

    // Stall in DONE; starts must not disturb the result.
    for (int i = 0; i < N; i++) f[i] = 12'($urandom_range(200, 207));
    run_resp("t4", er);
    for (int c = 0; c < 50; c++) begin
      start = (c % 7 == 3);
      cyc(1);
      chk("t4_valid", u_if.resp_valid, 1);
      chk("t4_resp", u_if.response, er);
    end
    start = 1'b0;
    handshake(er);

    // Abort during pair 7 measurement.
    pulse_start();
    cyc(7 * PAIR_LAT + CLR + 5);
    chk("t5_sel7", sel_a, 7);
    chk("t5_meas", ro_enable, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5_en", ro_enable, 0);
    chk("t5_clr", ro_reset, 1);
    chk("t5_busy", busy, 0);
    chk("t5_resp", u_if.response, 0);
    chk("t5_sel_a", sel_a, 0);
    chk("t5_sel_b", sel_b, 1);
    cyc(1);
    for (int i = 0; i < N; i++) f[i] = 12'($urandom_range(0, 4095));
    run_resp("t5r", er);
    handshake(er);

    // Random tables with frequent ties and saturation.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) f[i] = 12'hFFF;
        else f[i] = 12'($urandom_range(300, 303));
      end
      run_resp("rnd", er);
      if (r == 1) begin
        u_if.resp_ready = 1'b1;
        cyc(1);
        u_if.resp_ready = 1'b0;
        chk("rdy_early", u_if.resp_valid, 0);
      end else begin
        handshake(er);
      end
    end

    // resp_ready already high when DONE is entered.
    u_if.resp_ready = 1'b1;
    for (int i = 0; i < N; i++) f[i] = 12'(900 - i);
    run_resp("t7", er);
    cyc(1);
    chk("t7_one", u_if.resp_valid, 0);
    chk("t7_idle", busy, 0);
    u_if.resp_ready = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule
